// File: rtl/rr_lod_pkg.sv
// Shared constants, state encoding and sizing helper for the leading-one round-robin arbiter.
package rr_lod_pkg;
  localparam int N_REQ = 9;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] IDX_NONE = 5'b11111;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Width wide enough for 0..max_hold; never collapses to zero bits.
  function automatic int hold_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction
endpackage

// File: rtl/rr_lod_arbiter_lod.sv
// 9-bit leading-one detector: index of the highest set bit, 5'b11111 when the input is zero.
module rr_lod_arbiter_lod
  import rr_lod_pkg::*;
(
  input  logic [N_REQ-1:0] a,
  output logic [IDX_W-1:0] index
);
  always_comb begin
    index = IDX_NONE;
    for (int i = 0; i < N_REQ; i++) begin
      if (a[i]) index = IDX_W'(i);
    end
  end
endmodule

// File: rtl/rr_lod_arbiter.sv
// Round-robin arbiter for 9 requesters; grant is held until release_i or the hold watchdog fires.
module rr_lod_arbiter
  import rr_lod_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             release_i,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);
  localparam int HOLD_W = hold_w(MAX_HOLD);

  state_t              state, state_n;
  logic [N_REQ-1:0]    mask;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [N_REQ-1:0]    cand, cand_masked;
  logic [IDX_W-1:0]    idx_masked, idx_full, win_idx;
  logic                wd_expire, load, timeout_n;

  // The current owner never competes in its own release evaluation.
  assign cand        = (state == GRANT) ? (req & ~grant_onehot) : req;
  assign cand_masked = cand & mask;

  rr_lod_arbiter_lod u_lod_masked (.a(cand_masked), .index(idx_masked));
  rr_lod_arbiter_lod u_lod_full   (.a(cand),        .index(idx_full));

  assign win_idx   = (cand_masked != '0) ? idx_masked : idx_full;
  assign wd_expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    timeout_n = 1'b0;
    hold_n    = hold_cnt;
    case (state)
      IDLE: begin
        if (cand != '0) begin
          state_n = GRANT;
          load    = 1'b1;
          hold_n  = '0;
        end
      end
      GRANT: begin
        hold_n = hold_cnt + 1'b1;
        if (release_i || wd_expire) begin
          timeout_n = wd_expire && !release_i;
          hold_n    = '0;
          if (cand != '0) load = 1'b1;
          else            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= IDX_NONE;
      grant_onehot <= '0;
      timeout      <= 1'b0;
      mask         <= '1;
      hold_cnt     <= '0;
    end else begin
      state    <= state_n;
      timeout  <= timeout_n;
      hold_cnt <= hold_n;
      if (load) begin
        grant_valid  <= 1'b1;
        grant_idx    <= win_idx;
        grant_onehot <= N_REQ'(1) << win_idx;
        // Next search starts just below the new winner; winner 0 yields an empty mask (wrap).
        mask         <= (N_REQ'(1) << win_idx) - N_REQ'(1);
      end else if (state_n == IDLE) begin
        grant_valid  <= 1'b0;
        grant_idx    <= IDX_NONE;
        grant_onehot <= '0;
      end
    end
  end
endmodule
